lsu_unit: RTL
=============

// Module: lsu_unit
// PURPOSE
//  Load/store unit downstream of the instruction decoder. Consumes the decoder's memory-write enable and
//  5-bit access mask, issues word-wide req/ack transactions to data memory, splits misaligned accesses into
//  two word accesses, and returns sign/zero-extended load data to writeback. Stalls the core while busy.
// PARAMETERS
//  ALLOW_MISALIGNED  1   1: split word-crossing accesses in two; 0: flag o_err, no memory access
//  MAX_WAIT          16  cycles to wait for i_memAck per access before abort with o_err (2..255)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_reset        in   1   asynchronous, active-low reset
//  i_req          in   1   current instruction is a load/store (decoder wbSel=load or memWrEnable)
//  i_memWrEnable  in   1   1 = store, 0 = load
//  i_mask         in   5   [3:0] size (0001 B, 0011 H, 1111 W); [4] 1 = zero-extend load
//  i_addr         in   32  byte address from ALU
//  i_wdata        in   32  store data (rs2), right-aligned
//  o_stall        out  1   hold PC/pipeline this cycle
//  o_done         out  1   one-cycle pulse: access complete, o_rdata/o_err valid
//  o_rdata        out  32  extended load data (0 for stores)
//  o_err          out  1   misaligned-disallowed or timeout; valid with o_done
//  o_memReq       out  1   memory request
//  o_memWe        out  1   memory write
//  o_memAddr      out  32  word-aligned address ([1:0]=00)
//  o_memBe        out  4   byte enables
//  o_memWdata     out  32  write data, byte-lane aligned
//  i_memAck       in   1   access accepted/complete; i_memRdata valid same cycle
//  i_memRdata     in   32  read word
// BEHAVIOUR
//  - Reset: state IDLE; o_stall,o_done,o_err,o_memReq,o_memWe=0; o_memAddr,o_memBe,o_memWdata,o_rdata=0.
//  - Reset mid-access drops o_memReq immediately (async); no partial completion reported.
//  - FSM IDLE->ACC0->(ACC1)->DONE->IDLE.
//  - IDLE: i_req && i_mask[3:0]!=0 latches addr/wdata/mask/we, off=addr[1:0], be8={4'b0,mask[3:0]}<<off,
//    wd64={32'b0,wdata}<<(8*off); ->ACC0. i_mask[3:0]==0 ignored (no stall).
//  - be8[7:4]!=0 marks split. Split with ALLOW_MISALIGNED=0: IDLE->DONE with o_err=1, no o_memReq.
//  - ACC0: o_memReq=1, addr={a[31:2],2'b00}, be=be8[3:0], wdata=wd64[31:0]; held stable until i_memAck.
//    On ack: capture rdLo; ->ACC1 if split, else ->DONE.
//  - ACC1: addr=word+4 (mod 2^32: 0xFFFFFFFC wraps to 0x0), be=be8[7:4], wdata=wd64[63:32]; on ack capture
//    rdHi; ->DONE.
//  - Wait counter cleared on entry to ACC0/ACC1, +1 per cycle without ack; reaching MAX_WAIT with no ack
//    -> DONE, o_err=1, o_memReq drops. Ack on the MAX_WAIT-th cycle wins (no error).
//  - i_memAck outside ACC0/ACC1 ignored.
//  - DONE (1 cycle): o_done=1, o_stall=0; loads: r=({rdHi,rdLo}>>(8*off))[31:0], masked to size,
//    sign-extended from bit 7/15 unless i_mask[4]; stores: o_rdata=0. Always ->IDLE.
//  - o_stall = i_req && mask!=0 && state!=DONE (combinational, includes the IDLE accept cycle).
//  - o_rdata/o_err hold until next DONE.
//  - Latency: aligned, 0-wait ack = 2 stall cycles, o_done in 3rd; split adds 1 + wait cycles.
// TESTING
//  1 LW addr 0x100, ack 0 wait, rdata 0xDEADBEEF -> memAddr 0x100, be 1111, o_done cycle 3, o_rdata 0xDEADBEEF.
//  2 LB addr 0x203, rdata 0x80123456 -> be 1000, o_rdata 0xFFFFFF80; LBU (mask 10001) -> 0x00000080.
//  3 LHU addr 0x303, words 0xAB000000 / 0x000000CD -> be 1000 @0x300 then 0001 @0x304, o_rdata 0x0000CDAB.
//  4 SW addr 0x402, wdata 0x11223344 -> be 1100 wdata 0x33440000 @0x400, be 0011 wdata 0x00001122 @0x404.
//  5 LW addr 0x500, no ack for 16 cycles -> o_err=1 with o_done, o_memReq low; reset at wait 5 -> IDLE, req 0.
//  6 LH addr 0xFFFFFFFF -> second access o_memAddr 0x00000000; with ALLOW_MISALIGNED=0 -> o_err, no o_memReq.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit: turns decoder load/store requests into word-wide req/ack memory
// transactions. Word-crossing accesses are split in two, and load data is returned extended.
module lsu_unit #(
   parameter int ALLOW_MISALIGNED = 1,
   parameter int MAX_WAIT         = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_memWrEnable,
   input  logic [4:0]  i_mask,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_err,
   output logic        o_memReq,
   output logic        o_memWe,
   output logic [31:0] o_memAddr,
   output logic [3:0]  o_memBe,
   output logic [31:0] o_memWdata,
   input  logic        i_memAck,
   input  logic [31:0] i_memRdata
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} lsuState;

   lsuState     state;
   logic [1:0]  offReg;
   logic [7:0]  be8Reg;
   logic [63:0] wd64Reg;
   logic [4:0]  maskReg;
   logic        weReg;
   logic [31:0] rdLo;
   logic [7:0]  waitCnt;

   logic        accept;
   logic [7:0]  be8Next;
   logic [63:0] wd64Next;
   logic        splitNext;
   logic        splitReg;
   logic        timeoutHit;

   assign accept     = i_req && (i_mask[3:0] != 4'b0000);
   assign be8Next    = {4'b0000, i_mask[3:0]} << i_addr[1:0];
   assign wd64Next   = {32'b0, i_wdata} << {i_addr[1:0], 3'b000};
   assign splitNext  = (be8Next[7:4] != 4'b0000);
   assign splitReg   = (be8Reg[7:4] != 4'b0000);
   assign timeoutHit = (waitCnt == 8'(MAX_WAIT - 1));

   assign o_stall = accept && (state != DONE);

   // Shift the (hi,lo) word pair down to the access offset, then size-mask and extend.
   function automatic logic [31:0] extendLoad(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [4:0] mask);
      logic [31:0] sh;
      sh = 32'(pair >> {off, 3'b000});
      case (mask[3:0])
         4'b0001: extendLoad = mask[4] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         4'b0011: extendLoad = mask[4] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: extendLoad = sh;
      endcase
   endfunction

   // Single FSM; all memory-side and writeback outputs are registered here.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         offReg     <= 2'b00;
         be8Reg     <= 8'h00;
         wd64Reg    <= 64'h0;
         maskReg    <= 5'b0;
         weReg      <= 1'b0;
         rdLo       <= 32'h0;
         waitCnt    <= 8'h00;
         o_done     <= 1'b0;
         o_rdata    <= 32'h0;
         o_err      <= 1'b0;
         o_memReq   <= 1'b0;
         o_memWe    <= 1'b0;
         o_memAddr  <= 32'h0;
         o_memBe    <= 4'h0;
         o_memWdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  offReg  <= i_addr[1:0];
                  be8Reg  <= be8Next;
                  wd64Reg <= wd64Next;
                  maskReg <= i_mask;
                  weReg   <= i_memWrEnable;
                  if (splitNext && (ALLOW_MISALIGNED == 0)) begin
                     state   <= DONE;
                     o_done  <= 1'b1;
                     o_err   <= 1'b1;
                     o_rdata <= 32'h0;
                  end else begin
                     state      <= ACC0;
                     o_memReq   <= 1'b1;
                     o_memWe    <= i_memWrEnable;
                     o_memAddr  <= {i_addr[31:2], 2'b00};
                     o_memBe    <= be8Next[3:0];
                     o_memWdata <= wd64Next[31:0];
                     waitCnt    <= 8'h00;
                  end
               end
            end
            ACC0: begin
               if (i_memAck) begin
                  rdLo <= i_memRdata;
                  if (splitReg) begin
                     state      <= ACC1;
                     o_memAddr  <= o_memAddr + 32'd4;
                     o_memBe    <= be8Reg[7:4];
                     o_memWdata <= wd64Reg[63:32];
                     waitCnt    <= 8'h00;
                  end else begin
                     state    <= DONE;
                     o_memReq <= 1'b0;
                     o_memWe  <= 1'b0;
                     o_done   <= 1'b1;
                     o_err    <= 1'b0;
                     o_rdata  <= weReg ? 32'h0 : extendLoad({32'h0, i_memRdata}, offReg, maskReg);
                  end
               end else if (timeoutHit) begin
                  state    <= DONE;
                  o_memReq <= 1'b0;
                  o_memWe  <= 1'b0;
                  o_done   <= 1'b1;
                  o_err    <= 1'b1;
                  o_rdata  <= 32'h0;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            ACC1: begin
               if (i_memAck) begin
                  state    <= DONE;
                  o_memReq <= 1'b0;
                  o_memWe  <= 1'b0;
                  o_done   <= 1'b1;
                  o_err    <= 1'b0;
                  o_rdata  <= weReg ? 32'h0 : extendLoad({i_memRdata, rdLo}, offReg, maskReg);
               end else if (timeoutHit) begin
                  state    <= DONE;
                  o_memReq <= 1'b0;
                  o_memWe  <= 1'b0;
                  o_done   <= 1'b1;
                  o_err    <= 1'b1;
                  o_rdata  <= 32'h0;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            DONE: begin
               o_done <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
